run_sequencer: RTL and testbench

Host-side run controller that sits directly upstream of the processor top level and drives its `start` input. It loads a block of operand bytes into data memory through a write port, holds the processor in reset for a programmable number of cycles, releases it, and watches `halt`. It reports completion, the executed-cycle count, and a watchdog timeout.

---
 rtl/run_sequencer.sv | 152 +++++++++++++++
 tb/tb_run_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// Run controller: loads operand bytes into data memory, holds the processor in init,
// releases it, and reports completion, executed-cycle count and watchdog timeout.
module run_sequencer #(
    parameter int unsigned START_CYCLES = 2,
    parameter logic [15:0] TIMEOUT      = 16'd4095
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        go,
    input  logic [7:0]  base_addr,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        dut_start,
    input  logic        dut_halt,
    output logic        busy,
    output logic        done,
    output logic        timed_out,
    output logic [15:0] run_cycles
);

    localparam int unsigned SCW = (START_CYCLES < 2) ? 1 : $clog2(START_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StRun,
        StDone
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_ptr;
    logic [SCW-1:0]   r_start_cnt;
    logic             r_mem_we;
    logic [7:0]       r_mem_addr;
    logic [7:0]       r_mem_wdata;
    logic [15:0]      r_run_cycles;
    logic             r_timed_out;
    logic             w_beat;
    logic [15:0]      w_run_next;

    assign w_beat     = (r_state == StLoad) && load_valid;
    assign w_run_next = r_run_cycles + 16'd1;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        load_ready   = 1'b0;
        dut_start    = 1'b1;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            StIdle: begin
                busy = 1'b0;
                if (go) begin
                    w_state_next = StLoad;
                end
            end
            StLoad: begin
                load_ready = 1'b1;
                if (load_valid && load_last) begin
                    w_state_next = StStart;
                end
            end
            StStart: begin
                if (r_start_cnt == SCW'(1)) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                dut_start = 1'b0;
                // Halt takes priority over a coincident watchdog expiry.
                if (dut_halt || (w_run_next == TIMEOUT)) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                done         = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_ptr        <= 8'd0;
            r_start_cnt  <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 8'd0;
            r_mem_wdata  <= 8'd0;
            r_run_cycles <= 16'd0;
            r_timed_out  <= 1'b0;
        end else begin
            r_mem_we <= w_beat;
            if (w_beat) begin
                r_mem_addr  <= r_ptr;
                r_mem_wdata <= load_data;
                r_ptr       <= r_ptr + 8'd1;
            end
            case (r_state)
                StIdle: begin
                    if (go) begin
                        r_ptr        <= base_addr;
                        r_run_cycles <= 16'd0;
                        r_timed_out  <= 1'b0;
                    end
                end
                StLoad: begin
                    if (w_beat && load_last) begin
                        r_start_cnt <= SCW'(START_CYCLES);
                    end
                end
                StStart: begin
                    r_start_cnt <= r_start_cnt - SCW'(1);
                end
                StRun: begin
                    if (!dut_halt && (r_run_cycles != TIMEOUT)) begin
                        r_run_cycles <= w_run_next;
                        if (w_run_next == TIMEOUT) begin
                            r_timed_out <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign run_cycles = r_run_cycles;
    assign timed_out  = r_timed_out;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: timestamp-based phase model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_run_sequencer;

    localparam int SC = 2;
    localparam int TO = 50;

    logic        CLK;
    logic        reset;
    logic        go;
    logic [7:0]  base_addr;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;
    logic        load_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        dut_start;
    logic        dut_halt;
    logic        busy;
    logic        done;
    logic        timed_out;
    logic [15:0] run_cycles;

    run_sequencer #(
        .START_CYCLES(SC),
        .TIMEOUT     (16'(TO))
    ) u_dut (
        .CLK       (CLK),
        .reset     (reset),
        .go        (go),
        .base_addr (base_addr),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_last (load_last),
        .load_ready(load_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .dut_start (dut_start),
        .dut_halt  (dut_halt),
        .busy      (busy),
        .done      (done),
        .timed_out (timed_out),
        .run_cycles(run_cycles)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: phases are derived from the cycle at which each run milestone happened.
    int         cyc = 0;
    bit         m_valid = 1'b0;
    bit         m_open = 1'b0;
    int         m_start_from = -1;
    int         m_done_at = -1;
    logic [7:0] m_ptr = 8'd0;
    bit         e_we = 1'b0;
    logic [7:0] e_addr = 8'd0;
    logic [7:0] e_wdata = 8'd0;
    int         m_runc = 0;
    bit         m_to = 1'b0;

    // 0 idle, 1 load, 2 start, 3 run, 4 done
    function automatic int phase_of(input int c);
        if (!m_open) return 0;
        if (m_start_from < 0) return 1;
        if (c < m_start_from + SC) return 2;
        if (m_done_at < 0 || c < m_done_at) return 3;
        if (c == m_done_at) return 4;
        return 0;
    endfunction

    always @(posedge CLK) begin
        int p;
        p   = phase_of(cyc);
        cyc = cyc + 1;
        if (reset) begin
            m_valid = 1'b1;
            m_open  = 1'b0;
            e_we    = 1'b0;
            e_addr  = 8'd0;
            e_wdata = 8'd0;
            m_runc  = 0;
            m_to    = 1'b0;
        end else begin
            e_we = 1'b0;
            case (p)
                0: if (go) begin
                    m_open       = 1'b1;
                    m_start_from = -1;
                    m_done_at    = -1;
                    m_ptr        = base_addr;
                    m_runc       = 0;
                    m_to         = 1'b0;
                end
                1: if (load_valid) begin
                    e_we    = 1'b1;
                    e_addr  = m_ptr;
                    e_wdata = load_data;
                    m_ptr   = m_ptr + 8'd1;
                    if (load_last) m_start_from = cyc;
                end
                3: if (dut_halt) begin
                    m_done_at = cyc;
                end else begin
                    m_runc = m_runc + 1;
                    if (m_runc == TO) begin
                        m_done_at = cyc;
                        m_to      = 1'b1;
                    end
                end
                4: m_open = 1'b0;
                default: ;
            endcase
        end
    end

    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         n_done = 0;

    always @(negedge CLK) begin
        int p;
        if (m_valid) begin
            p = phase_of(cyc);
            chk("dut_start",  32'(dut_start),  32'(p != 3));
            chk("load_ready", 32'(load_ready), 32'(p == 1));
            chk("busy",       32'(busy),       32'(p != 0));
            chk("done",       32'(done),       32'(p == 4));
            chk("mem_we",     32'(mem_we),     32'(e_we));
            chk("mem_addr",   32'(mem_addr),   32'(e_addr));
            chk("mem_wdata",  32'(mem_wdata),  32'(e_wdata));
            chk("run_cycles", 32'(run_cycles), 32'(m_runc));
            chk("timed_out",  32'(timed_out),  32'(m_to));
            if (mem_we === 1'b1) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
            end
            if (done === 1'b1) n_done++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        n_done = 0;
    endtask

    task automatic start_run(input logic [7:0] base);
        go        = 1'b1;
        base_addr = base;
        tick();
        go = 1'b0;
    endtask

    task automatic beat(input logic [7:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // n RUN cycles with halt low, then halt high for one sampled cycle.
    task automatic finish_run(input int n);
        dut_halt = 1'b0;
        repeat (n) tick();
        dut_halt = 1'b1;
        tick();
        dut_halt = 1'b0;
    endtask

    task automatic chk_writes(input string tag, input logic [7:0] a0, input int n,
                              input logic [7:0] d0, input logic [7:0] dstep);
        chk({tag, " write count"}, 32'(wr_addr_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            chk({tag, " write addr"}, 32'(wr_addr_q[i]), 32'(8'(a0 + 8'(i))));
            chk({tag, " write data"}, 32'(wr_data_q[i]), 32'(8'(d0 + 8'(i) * dstep)));
        end
    endtask

    initial begin
        reset      = 1'b1;
        go         = 1'b0;
        base_addr  = 8'd0;
        load_valid = 1'b0;
        load_data  = 8'd0;
        load_last  = 1'b0;
        dut_halt   = 1'b0;

        // Reset with inputs toggling
        repeat (2) begin
            go         = 1'($urandom);
            base_addr  = 8'($urandom);
            load_valid = 1'($urandom);
            load_data  = 8'($urandom);
            load_last  = 1'($urandom);
            dut_halt   = 1'($urandom);
            tick();
            chk("reset dut_start", 32'(dut_start), 32'd1);
            chk("reset busy", 32'(busy), 32'd0);
            chk("reset run_cycles", 32'(run_cycles), 32'd0);
            chk("reset mem_we", 32'(mem_we), 32'd0);
        end
        reset      = 1'b0;
        go         = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        dut_halt   = 1'b0;
        tick();

        // Normal run
        clear_log();
        start_run(8'h10);
        chk("normal load_ready", 32'(load_ready), 32'd1);
        for (int i = 0; i < 4; i++) beat(8'(8'hA1 + i), i == 3);
        chk("normal start c1", 32'(dut_start), 32'd1);
        tick();
        chk("normal start c2", 32'(dut_start), 32'd1);
        tick();
        chk("normal run c1", 32'(dut_start), 32'd0);
        finish_run(20);
        chk("normal done", 32'(done), 32'd1);
        chk("normal run_cycles", 32'(run_cycles), 32'd20);
        chk("normal timed_out", 32'(timed_out), 32'd0);
        tick();
        tick();
        chk("normal busy after", 32'(busy), 32'd0);
        chk("normal done count", 32'(n_done), 32'd1);
        chk_writes("normal", 8'h10, 4, 8'hA1, 8'd1);

        // Address wrap with a two-cycle stall
        clear_log();
        start_run(8'hFE);
        beat(8'h11, 1'b0);
        tick();
        tick();
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b1);
        repeat (SC) tick();
        finish_run(3);
        chk("wrap run_cycles", 32'(run_cycles), 32'd3);
        tick();
        chk_writes("wrap", 8'hFE, 3, 8'h11, 8'h11);

        // Watchdog
        clear_log();
        start_run(8'h20);
        beat(8'h5A, 1'b1);
        repeat (SC) tick();
        dut_halt = 1'b0;
        repeat (TO) tick();
        chk("wdog done", 32'(done), 32'd1);
        chk("wdog timed_out", 32'(timed_out), 32'd1);
        chk("wdog run_cycles", 32'(run_cycles), 32'd50);
        chk("wdog dut_start", 32'(dut_start), 32'd1);
        tick();
        chk("wdog hold timed_out", 32'(timed_out), 32'd1);

        // Halt and timeout in the same cycle
        clear_log();
        start_run(8'h30);
        beat(8'h01, 1'b1);
        repeat (SC) tick();
        finish_run(TO - 1);
        chk("tie done", 32'(done), 32'd1);
        chk("tie timed_out", 32'(timed_out), 32'd0);
        chk("tie run_cycles", 32'(run_cycles), 32'd49);
        tick();

        // Minimum latency: go, one beat, halt in first RUN cycle -> done 5 edges on
        clear_log();
        start_run(8'h31);
        beat(8'h02, 1'b1);
        repeat (SC) tick();
        finish_run(0);
        chk("minlat done", 32'(done), 32'd1);
        chk("minlat run_cycles", 32'(run_cycles), 32'd0);
        tick();

        // Reset mid-RUN, with go pulsed during LOAD
        clear_log();
        start_run(8'h40);
        go        = 1'b1;
        base_addr = 8'h80;
        beat(8'h07, 1'b0);
        go = 1'b0;
        beat(8'h08, 1'b1);
        repeat (SC) tick();
        dut_halt = 1'b0;
        repeat (10) tick();
        chk("midrun run_cycles", 32'(run_cycles), 32'd10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrun busy", 32'(busy), 32'd0);
        chk("midrun dut_start", 32'(dut_start), 32'd1);
        chk("midrun run_cycles", 32'(run_cycles), 32'd0);
        chk("midrun done", 32'(done), 32'd0);
        tick();
        tick();
        chk("midrun done count", 32'(n_done), 32'd0);
        chk_writes("midrun", 8'h40, 2, 8'h07, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
